// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter with lock-in: each input holds priority for up to its
// weight in consecutive handshakes. Define WRR_ARB_PERF_EN for the handshake counter.
module wrr_arb_tree #(
  parameter int NumIn       = 8,
  parameter int DataWidth   = 32,
  parameter int WeightWidth = 4,
  parameter int IdxWidth    = $clog2(NumIn)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  input  logic [NumIn-1:0]           req_i,
  output logic [NumIn-1:0]           gnt_o,
  input  logic [NumIn*DataWidth-1:0] data_i,
  output logic                       req_o,
  input  logic                       gnt_i,
  output logic [DataWidth-1:0]       data_o,
  output logic [IdxWidth-1:0]        idx_o,
  output logic [31:0]                hs_cnt_o
);

  localparam int CntW = WeightWidth + 1;

  logic [IdxWidth-1:0]    cur_q, cur_d;
  logic [WeightWidth-1:0] cnt_q, cnt_d;
  logic                   lock_q, lock_d;
  logic [NumIn-1:0]       req_q, req_d;

  logic [WeightWidth-1:0] weight_s [NumIn];
  logic [DataWidth-1:0]   data_s   [NumIn];
  logic [IdxWidth-1:0]    sel_s;
  logic [CntW-1:0]        w_sel_s, base_s, inc_s;
  logic                   hs_s;

  for (genvar g = 0; g < NumIn; g++) begin : g_unpack
    assign weight_s[g] = weight_i[g*WeightWidth +: WeightWidth];
    assign data_s[g]   = data_i[g*DataWidth +: DataWidth];
  end

  // First set bit strictly above ptr in circular order; ptr itself only if it is the sole one.
  function automatic logic [IdxWidth-1:0] next_above(input logic [NumIn-1:0] vec,
                                                     input logic [IdxWidth-1:0] ptr);
    logic [IdxWidth-1:0] res;
    logic [IdxWidth-1:0] jj;
    logic                found;
    res   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NumIn; k++) begin
      jj = IdxWidth'((int'(ptr) + k) % NumIn);
      if (!found && vec[jj]) begin
        res   = jj;
        found = 1'b1;
      end else begin
        res   = res;
      end
    end
    return res;
  endfunction

  // Selection and output steering
  always_comb begin
    req_d = lock_q ? req_q : req_i;
    sel_s = cur_q;
    if (req_d[cur_q]) begin
      sel_s = cur_q;
    end else begin
      sel_s = next_above(req_d, cur_q);
    end
    req_o        = |req_d;
    idx_o        = sel_s;
    data_o       = data_s[sel_s];
    gnt_o        = '0;
    gnt_o[sel_s] = gnt_i & req_d[sel_s];
    hs_s         = req_o & gnt_i;
  end

  // Turn accounting: a zero weight field behaves as a weight of one
  always_comb begin
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    lock_d  = req_o & ~gnt_i;
    w_sel_s = (weight_s[sel_s] == '0) ? CntW'(1) : {1'b0, weight_s[sel_s]};
    base_s  = (sel_s == cur_q) ? {1'b0, cnt_q} : '0;
    inc_s   = base_s + CntW'(1);
    if (hs_s) begin
      if (inc_s < w_sel_s) begin
        cur_d = sel_s;
        cnt_d = inc_s[WeightWidth-1:0];
      end else begin
        cur_d = next_above(req_d, sel_s);
        cnt_d = '0;
      end
    end else begin
      cur_d = cur_q;
      cnt_d = cnt_q;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      cur_q  <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      req_q  <= '0;
    end else begin
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      req_q  <= req_d;
    end
  end

`ifdef WRR_ARB_PERF_EN
  logic [31:0] hs_cnt_q, hs_cnt_d;

  // Free-running handshake counter, wraps naturally
  always_comb begin
    hs_cnt_d = hs_s ? (hs_cnt_q + 32'd1) : hs_cnt_q;
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      hs_cnt_q <= 32'd0;
    end else begin
      hs_cnt_q <= hs_cnt_d;
    end
  end

  assign hs_cnt_o = hs_cnt_q;
`else
  assign hs_cnt_o = 32'd0;
`endif

  wrr_arb_tree_chk #(.NumIn(NumIn), .IdxWidth(IdxWidth)) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .gnt_i   (gnt_i),
    .req_o   (req_o),
    .idx_o   (idx_o),
    .lock_q  (lock_q),
    .req_q   (req_q)
  );

endmodule

// Simulation-only protocol checks for wrr_arb_tree.
module wrr_arb_tree_chk #(
  parameter int NumIn    = 8,
  parameter int IdxWidth = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                flush_i,
  input logic [NumIn-1:0]    req_i,
  input logic [NumIn-1:0]    gnt_o,
  input logic                gnt_i,
  input logic                req_o,
  input logic [IdxWidth-1:0] idx_o,
  input logic                lock_q,
  input logic [NumIn-1:0]    req_q
);

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
  a_gnt_needs_ready: assert property (@(posedge clk_i) disable iff (rst_i) (|gnt_o) |-> gnt_i);
  a_hs_grants_sel: assert property (@(posedge clk_i) disable iff (rst_i)
                                    (req_o && gnt_i) |-> gnt_o[idx_o]);
  a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                                  lock_q |-> $stable(idx_o));
  // A stalled master must keep every request that was locked in
  a_no_drop: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                              lock_q |-> ((req_i & req_q) == req_q));

endmodule
